opmode_ctrl: RTL and testbench

- Control-side counterpart of the X/Y/Z operand multiplexers in the DSP48E1 model.
- Takes the raw 7-bit OPMODE, optionally registers it (OPMODEREG), and decodes it into the x_sel/y_sel/z_sel buses that drive the muxes.
- Detects illegal OPMODE combinations, forces a safe all-zero selection when one occurs, and keeps a sticky error flag and a saturating error count.
- Tracks multiplier-path latency so downstream logic knows when the M operand is valid after a mode switch.

---
 rtl/opmode_ctrl.sv | 132 +++++++++++++
 tb/tb_opmode_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/opmode_ctrl.sv
// OPMODE control path for the DSP X/Y/Z operand muxes: optional OPMODE register,
// select decode with illegal-mode squash, error tracking and multiplier-latency tracking.
module opmode_ctrl #(
    parameter int OPMODEREG = 1,
    parameter int MREG_LAT  = 1,
    parameter int ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce_opmode,
    input  logic [6:0]       opmode_in,
    input  logic             err_clr,
    output logic [6:0]       opmode_q,
    output logic [1:0]       x_sel,
    output logic [1:0]       y_sel,
    output logic [2:0]       z_sel,
    output logic             illegal,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt,
    output logic             mult_ready,
    output logic             opmode_chg
);

    localparam logic [2:0] LAT_MAX = 3'(MREG_LAT);

    logic [6:0]       prev_op_q;
    logic [2:0]       lat_q, lat_d, lat_eff;
    logic             err_sticky_q, err_sticky_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [1:0]       x_raw, y_raw;
    logic [2:0]       z_raw;
    logic             use_mult;

    // Effective OPMODE: one CE-gated register stage, or a straight wire.
    generate
        if (OPMODEREG != 0) begin : g_opreg
            logic [6:0] op_reg_q;

            // NOTE: sequential state is written with non-blocking assignments only.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    op_reg_q <= '0;
                end else if (ce_opmode) begin
                    op_reg_q <= opmode_in;
                end
            end

            assign opmode_q = op_reg_q;
        end else begin : g_opcomb
            logic unused_ce;

            assign unused_ce = ce_opmode;
            assign opmode_q  = opmode_in;
        end
    endgenerate

    assign x_raw = opmode_q[1:0];
    assign y_raw = opmode_q[3:2];
    assign z_raw = opmode_q[6:4];

    always_comb begin
        // NOTE: every combinational output gets a default first, so no latch is inferred.
        illegal = 1'b0;
        if ((x_raw == 2'b01) != (y_raw == 2'b01)) begin
            illegal = 1'b1;
        end
        if (z_raw == 3'b111) begin
            illegal = 1'b1;
        end
        if (z_raw == 3'b100 && opmode_q[3:0] != 4'b1000) begin
            illegal = 1'b1;
        end
    end

    always_comb begin
        x_sel = 2'b00;
        y_sel = 2'b00;
        z_sel = 3'b000;
        if (!illegal) begin
            x_sel = x_raw;
            y_sel = y_raw;
            z_sel = z_raw;
        end
    end

    assign use_mult   = !illegal && (x_raw == 2'b01) && (y_raw == 2'b01);
    assign opmode_chg = (opmode_q != prev_op_q);

    // The cycle in which OPMODE changes always counts as zero, so a stale count
    // from a previous multiply mode can never report M valid early.
    assign lat_eff    = opmode_chg ? 3'd0 : lat_q;
    assign mult_ready = use_mult && (lat_eff == LAT_MAX);

    always_comb begin
        lat_d = 3'd0;
        if (use_mult) begin
            lat_d = (lat_eff >= LAT_MAX) ? LAT_MAX : lat_eff + 3'd1;
        end
    end

    always_comb begin
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        if (err_clr) begin
            err_sticky_d = 1'b0;
            err_cnt_d    = '0;
        end else if (illegal) begin
            err_sticky_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_op_q    <= '0;
            lat_q        <= '0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            prev_op_q    <= opmode_q;
            lat_q        <= lat_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_opmode_ctrl.sv
// Directed bench for opmode_ctrl: registered instance (MREG_LAT=2, ERR_W=2) and
// pass-through instance (MREG_LAT=0, ERR_W=8) driven from the same inputs.
module tb_opmode_ctrl;

    logic       clk;
    logic       rst;
    logic       ce_opmode;
    logic [6:0] opmode_in;
    logic       err_clr;

    logic [6:0] a_opmode_q, b_opmode_q;
    logic [1:0] a_x_sel, a_y_sel, b_x_sel, b_y_sel;
    logic [2:0] a_z_sel, b_z_sel;
    logic       a_illegal, a_err_sticky, a_mult_ready, a_opmode_chg;
    logic       b_illegal, b_err_sticky, b_mult_ready, b_opmode_chg;
    logic [1:0] a_err_cnt;
    logic [7:0] b_err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    opmode_ctrl #(.OPMODEREG(1), .MREG_LAT(2), .ERR_W(2)) dut_a (
        .clk(clk), .rst(rst), .ce_opmode(ce_opmode), .opmode_in(opmode_in), .err_clr(err_clr),
        .opmode_q(a_opmode_q), .x_sel(a_x_sel), .y_sel(a_y_sel), .z_sel(a_z_sel),
        .illegal(a_illegal), .err_sticky(a_err_sticky), .err_cnt(a_err_cnt),
        .mult_ready(a_mult_ready), .opmode_chg(a_opmode_chg)
    );

    opmode_ctrl #(.OPMODEREG(0), .MREG_LAT(0), .ERR_W(8)) dut_b (
        .clk(clk), .rst(rst), .ce_opmode(ce_opmode), .opmode_in(opmode_in), .err_clr(err_clr),
        .opmode_q(b_opmode_q), .x_sel(b_x_sel), .y_sel(b_y_sel), .z_sel(b_z_sel),
        .illegal(b_illegal), .err_sticky(b_err_sticky), .err_cnt(b_err_cnt),
        .mult_ready(b_mult_ready), .opmode_chg(b_opmode_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        ce_opmode = 1'b1;
        opmode_in = 7'h35;
        err_clr   = 1'b0;
        #2;
        check("rst_a_opq",    32'(a_opmode_q), 32'h00);
        check("rst_a_sel",    32'({a_z_sel, a_y_sel, a_x_sel}), 32'h0);
        check("rst_a_ill",    32'(a_illegal), 32'd0);
        check("rst_a_err",    32'({a_err_sticky, a_err_cnt}), 32'd0);
        check("rst_a_ready",  32'(a_mult_ready), 32'd0);
        check("rst_a_chg",    32'(a_opmode_chg), 32'd0);
        check("rst_b_opq",    32'(b_opmode_q), 32'h35);
        check("rst_b_chg",    32'(b_opmode_chg), 32'd1);

        step();
        rst = 1'b0;
        step();
        check("load_opq",  32'(a_opmode_q), 32'h35);
        check("load_z",    32'(a_z_sel), 32'd3);
        check("load_y",    32'(a_y_sel), 32'd1);
        check("load_x",    32'(a_x_sel), 32'd1);
        check("load_ill",  32'(a_illegal), 32'd0);
        check("load_chg1", 32'(a_opmode_chg), 32'd1);
        step();
        check("load_chg2", 32'(a_opmode_chg), 32'd0);

        // Multiply latency
        opmode_in = 7'h00;
        step();
        step();
        check("idle_ready", 32'(a_mult_ready), 32'd0);
        opmode_in = 7'h05;
        #1;
        check("b_ready_comb", 32'(b_mult_ready), 32'd1);
        step();
        check("lat_c1", 32'(a_mult_ready), 32'd0);
        check("lat_c1_chg", 32'(a_opmode_chg), 32'd1);
        step();
        check("lat_c2", 32'(a_mult_ready), 32'd0);
        step();
        check("lat_c3", 32'(a_mult_ready), 32'd1);
        step();
        check("lat_c4", 32'(a_mult_ready), 32'd1);
        opmode_in = 7'h0A;
        step();
        check("sw_opq",   32'(a_opmode_q), 32'h0A);
        check("sw_ready", 32'(a_mult_ready), 32'd0);
        check("sw_xy",    32'({a_y_sel, a_x_sel}), 32'hA);

        // Illegal X/Y mismatch with saturating count
        opmode_in = 7'h04;
        step();
        check("ill_flag",   32'(a_illegal), 32'd1);
        check("ill_sel",    32'({a_z_sel, a_y_sel, a_x_sel}), 32'h0);
        check("ill_cnt0",   32'(a_err_cnt), 32'd0);
        step();
        check("ill_cnt1",   32'(a_err_cnt), 32'd1);
        check("ill_sticky", 32'(a_err_sticky), 32'd1);
        for (int i = 0; i < 4; i++) step();
        check("ill_sat",    32'(a_err_cnt), 32'd3);
        check("b_cnt6",     32'(b_err_cnt), 32'd6);

        // Clear collides with an illegal cycle
        err_clr = 1'b1;
        step();
        check("clr_cnt",    32'(a_err_cnt), 32'd0);
        check("clr_sticky", 32'(a_err_sticky), 32'd0);
        check("clr_b_cnt",  32'(b_err_cnt), 32'd0);
        err_clr = 1'b0;
        step();
        check("resume_cnt",   32'(a_err_cnt), 32'd1);
        check("resume_b_cnt", 32'(b_err_cnt), 32'd1);

        // Z rules, on the pass-through instance
        opmode_in = 7'h48;
        #1;
        check("z48_ill", 32'(b_illegal), 32'd0);
        check("z48_sel", 32'({b_z_sel, b_y_sel, b_x_sel}), 32'h48);
        opmode_in = 7'h40;
        #1;
        check("z40_ill", 32'(b_illegal), 32'd1);
        check("z40_z",   32'(b_z_sel), 32'd0);
        opmode_in = 7'h70;
        #1;
        check("z70_ill", 32'(b_illegal), 32'd1);
        opmode_in = 7'h60;
        #1;
        check("z60_ill", 32'(b_illegal), 32'd0);
        check("z60_z",   32'(b_z_sel), 32'd6);
        step();
        check("a_z60_z", 32'(a_z_sel), 32'd6);

        // CE hold while the input toggles
        opmode_in = 7'h05;
        step();
        check("ce_load", 32'(a_opmode_q), 32'h05);
        step();
        ce_opmode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            opmode_in = (i % 2 == 0) ? 7'h33 : 7'h05;
            step();
            check("ce_hold_opq", 32'(a_opmode_q), 32'h05);
            check("ce_hold_chg", 32'(a_opmode_chg), 32'd0);
        end
        check("pre_rst_ready", 32'(a_mult_ready), 32'd1);

        // Asynchronous reset mid-multiply, then a full latency restart
        #2;
        rst = 1'b1;
        #1;
        check("arst_ready",  32'(a_mult_ready), 32'd0);
        check("arst_opq",    32'(a_opmode_q), 32'h00);
        check("arst_sticky", 32'(a_err_sticky), 32'd0);
        opmode_in = 7'h05;
        ce_opmode = 1'b1;
        #1;
        rst = 1'b0;
        step();
        check("rel_opq", 32'(a_opmode_q), 32'h05);
        check("rel_c1",  32'(a_mult_ready), 32'd0);
        step();
        check("rel_c2",  32'(a_mult_ready), 32'd0);
        step();
        check("rel_c3",  32'(a_mult_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
